// File: rtl/cp0_irq_ctrl.sv
// CP0 status/cause/EPC/PRId registers plus a per-line level/edge interrupt controller.
// irq and dout are combinational from registered state; hwint reaches IP after SYNC_STAGES edges. There is no backpressure.
module cp0_irq_ctrl #(
  parameter int          NUM_IRQ     = 6,
  parameter logic [5:0]  EDGE_MASK   = 6'b000000,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] PRID_VAL    = 32'h0000_0001
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [29:0]        pc,
  input  logic [31:0]        din,
  input  logic [NUM_IRQ-1:0] hwint,
  input  logic [4:0]         sel,
  input  logic               we,
  input  logic               exl_set,
  input  logic               exl_clr,
  input  logic               exc_req,
  input  logic [4:0]         exc_code,
  output logic               irq,
  output logic [29:0]        epc,
  output logic               exl,
  output logic [31:0]        dout
);

  localparam logic [4:0] SEL_SR    = 5'd12;
  localparam logic [4:0] SEL_CAUSE = 5'd13;
  localparam logic [4:0] SEL_EPC   = 5'd14;
  localparam logic [4:0] SEL_PRID  = 5'd15;
  localparam logic [NUM_IRQ-1:0] EMASK = EDGE_MASK[NUM_IRQ-1:0];

  logic [NUM_IRQ-1:0] s;
  logic [NUM_IRQ-1:0] p;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] pend_clr;
  logic [NUM_IRQ-1:0] ip;
  logic [NUM_IRQ-1:0] im;
  logic               ie;
  logic [4:0]         exc_cd;
  logic               sr_we;
  logic               cause_we;
  logic               epc_we;

  generate
    if (SYNC_STAGES == 2) begin : g_sync
      logic [NUM_IRQ-1:0] sync1;
      logic [NUM_IRQ-1:0] sync2;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync1 <= '0;
          sync2 <= '0;
        end else begin
          sync1 <= hwint;
          sync2 <= sync1;
        end
      end
      assign s = sync2;
    end else begin : g_bypass
      assign s = hwint;
    end
  endgenerate

  assign sr_we    = we && (sel == SEL_SR);
  assign cause_we = we && (sel == SEL_CAUSE);
  assign epc_we   = we && (sel == SEL_EPC);

  // Software can only clear pending edges; a simultaneous new edge still sets.
  assign rise     = s & ~p & EMASK;
  assign pend_clr = cause_we ? ~din[10 +: NUM_IRQ] : '0;
  assign ip       = (EMASK & pend) | (~EMASK & s);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p    <= '0;
      pend <= '0;
    end else begin
      p    <= s;
      pend <= (pend & ~pend_clr) | rise;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im     <= '0;
      ie     <= 1'b0;
      exl    <= 1'b0;
      exc_cd <= 5'd0;
      epc    <= 30'd0;
    end else begin
      if (sr_we) begin
        im <= din[10 +: NUM_IRQ];
        ie <= din[0];
      end
      if (exl_set)      exl <= 1'b1;
      else if (exl_clr) exl <= 1'b0;
      else if (sr_we)   exl <= din[1];
      if (exl_set) exc_cd <= exc_req ? exc_code : 5'd0;
      // A nested entry keeps the EPC of the outermost exception.
      if (exl_set && !exl) epc <= pc;
      else if (epc_we)     epc <= din[31:2];
    end
  end

  assign irq = ie & ~exl & (|(ip & im));

  always_comb begin
    dout = 32'h0;
    case (sel)
      SEL_SR: begin
        dout[10 +: NUM_IRQ] = im;
        dout[1]             = exl;
        dout[0]             = ie;
      end
      SEL_CAUSE: begin
        dout[10 +: NUM_IRQ] = ip;
        dout[6:2]           = exc_cd;
      end
      SEL_EPC:  dout = {epc, 2'b00};
      SEL_PRID: dout = PRID_VAL;
      default:  dout = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed bench for cp0_irq_ctrl: cycle-by-cycle model comparison plus literal checks.
module tb_cp0_irq_ctrl;

  localparam logic [5:0] M_EDGE = 6'b000100;

  logic        clk;
  logic        rst;
  logic [29:0] pc;
  logic [31:0] din;
  logic [5:0]  hwint;
  logic [1:0]  hwint2;
  logic [4:0]  sel;
  logic        we, exl_set, exl_clr, exc_req;
  logic [4:0]  exc_code;
  logic        irq, exl, irq2, exl2;
  logic [29:0] epc, epc2;
  logic [31:0] dout, dout2;

  int vectors = 0;
  int miscompares = 0;

  cp0_irq_ctrl #(.NUM_IRQ(6), .EDGE_MASK(M_EDGE), .SYNC_STAGES(2), .PRID_VAL(32'h0000_0001)) dut (
    .clk(clk), .rst(rst), .pc(pc), .din(din), .hwint(hwint), .sel(sel), .we(we),
    .exl_set(exl_set), .exl_clr(exl_clr), .exc_req(exc_req), .exc_code(exc_code),
    .irq(irq), .epc(epc), .exl(exl), .dout(dout));

  cp0_irq_ctrl #(.NUM_IRQ(2)) dut2 (
    .clk(clk), .rst(rst), .pc(pc), .din(din), .hwint(hwint2), .sel(sel), .we(we),
    .exl_set(exl_set), .exl_clr(exl_clr), .exc_req(exc_req), .exc_code(exc_code),
    .irq(irq2), .epc(epc2), .exl(exl2), .dout(dout2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: hist0/hist1 are the hwint samples from one and two edges ago.
  logic [5:0]  m_im, m_pend, hist0, hist1, m_prev;
  logic        m_ie, m_exl;
  logic [29:0] m_epc;
  logic [4:0]  m_code;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_im = 0; m_pend = 0; hist0 = 0; hist1 = 0; m_prev = 0;
      m_ie = 0; m_exl = 0; m_epc = 0; m_code = 0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (M_EDGE[i]) begin
          if (we && sel == 5'd13 && !din[10+i]) m_pend[i] = 1'b0;
          if (hist1[i] && !m_prev[i]) m_pend[i] = 1'b1;
        end
      end
      m_prev = hist1;
      hist1  = hist0;
      hist0  = hwint;
      if (exl_set && !m_exl) m_epc = pc;
      else if (we && sel == 5'd14) m_epc = din[31:2];
      if (exl_set) m_code = exc_req ? exc_code : 5'd0;
      if (we && sel == 5'd12) begin
        m_im = din[15:10];
        m_ie = din[0];
      end
      if (exl_set) m_exl = 1'b1;
      else if (exl_clr) m_exl = 1'b0;
      else if (we && sel == 5'd12) m_exl = din[1];
    end
  end

  function automatic logic [5:0] m_ip();
    return (M_EDGE & m_pend) | (~M_EDGE & hist1);
  endfunction

  function automatic logic m_irq();
    return m_ie && !m_exl && ((m_ip() & m_im) != 6'd0);
  endfunction

  function automatic logic [31:0] m_dout(input logic [4:0] s);
    case (s)
      5'd12:   return (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
      5'd13:   return (32'(m_ip()) << 10) | (32'(m_code) << 2);
      5'd14:   return {m_epc, 2'b00};
      5'd15:   return 32'h0000_0001;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_irq", 32'(irq), 32'(m_irq()));
    check("model_exl", 32'(exl), 32'(m_exl));
    check("model_epc", 32'(epc), 32'(m_epc));
    check("model_dout", dout, m_dout(sel));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] s, input logic [31:0] d);
    we = 1'b1; sel = s; din = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [4:0] s, input logic [31:0] exp);
    sel = s;
    #1;
    check(name, dout, exp);
  endtask

  task automatic pulse_set(input logic [29:0] a, input logic rq, input logic [4:0] cd);
    pc = a; exc_req = rq; exc_code = cd; exl_set = 1'b1;
    tick();
    exl_set = 1'b0; exc_req = 1'b0;
  endtask

  task automatic pulse_clr();
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 0; pc = 0; din = 0; hwint = 0; hwint2 = 0; sel = 0;
    we = 0; exl_set = 0; exl_clr = 0; exc_req = 0; exc_code = 0;
    tick(); tick();
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_exl", 32'(exl), 32'h0);
    rst = 1;
    tick();

    // Level line 0: irq two edges after hwint rises.
    mtc0(5'd12, 32'h0000_0401);
    hwint[0] = 1'b1;
    tick();
    check("level_edge1_irq", 32'(irq), 32'h0);
    tick();
    check("level_edge2_irq", 32'(irq), 32'h1);
    rd("level_cause", 5'd13, 32'h0000_0400);
    pulse_set(30'h0C00_0010, 1'b0, 5'd0);
    check("int_epc", 32'(epc), 32'h0C00_0010);
    check("int_exl", 32'(exl), 32'h1);
    check("int_irq", 32'(irq), 32'h0);
    rd("int_cause", 5'd13, 32'h0000_0400);
    hwint[0] = 1'b0;
    pulse_clr();
    tick(); tick();

    // Edge line 2: irq three edges after a one-cycle pulse and latched.
    mtc0(5'd12, 32'h0000_1001);
    hwint[2] = 1'b1;
    tick();
    hwint[2] = 1'b0;
    tick();
    check("edge_edge2_irq", 32'(irq), 32'h0);
    tick();
    check("edge_edge3_irq", 32'(irq), 32'h1);
    tick(); tick();
    check("edge_hold_irq", 32'(irq), 32'h1);
    mtc0(5'd13, 32'h0);
    check("edge_clear_irq", 32'(irq), 32'h0);

    // New edge coinciding with the clearing write keeps the pend bit.
    hwint[2] = 1'b1;
    tick();
    hwint[2] = 1'b0;
    tick();
    we = 1'b1; sel = 5'd13; din = 32'h0;
    tick();
    we = 1'b0;
    check("collide_irq", 32'(irq), 32'h1);
    rd("collide_cause", 5'd13, 32'h0000_1000);
    mtc0(5'd13, 32'hFFFF_FFFF);
    check("write1_keeps_irq", 32'(irq), 32'h1);
    mtc0(5'd13, 32'h0);
    mtc0(5'd13, 32'hFFFF_FFFF);
    check("write1_nosets_irq", 32'(irq), 32'h0);
    rd("write1_cause", 5'd13, 32'h0);

    // Nested exception keeps the first EPC, ExcCode follows the latest entry.
    mtc0(5'd12, 32'h0);
    pulse_set(30'h0000_1234, 1'b1, 5'd12);
    check("nest1_epc", 32'(epc), 32'h0000_1234);
    rd("nest1_cause", 5'd13, 32'h0000_0030);
    pulse_set(30'h0000_5678, 1'b1, 5'd8);
    check("nest2_epc", 32'(epc), 32'h0000_1234);
    rd("nest2_cause", 5'd13, 32'h0000_0020);
    pulse_clr();
    check("nest_clr_exl", 32'(exl), 32'h0);
    check("nest_clr_epc", 32'(epc), 32'h0000_1234);

    // Same-cycle collisions.
    exl_set = 1'b1; exl_clr = 1'b1; we = 1'b1; sel = 5'd12; din = 32'h0; pc = 30'h0000_0777;
    tick();
    exl_set = 1'b0; exl_clr = 1'b0; we = 1'b0;
    check("coll_exl", 32'(exl), 32'h1);
    rd("coll_sr", 5'd12, 32'h0000_0002);
    pulse_clr();
    exl_set = 1'b1; we = 1'b1; sel = 5'd14; din = 32'hDEAD_BEE0; pc = 30'h0000_0ABC;
    tick();
    exl_set = 1'b0; we = 1'b0;
    check("coll_epc", 32'(epc), 32'h0000_0ABC);
    pulse_clr();
    mtc0(5'd14, 32'hDEAD_BEE0);
    check("mtc0_epc", 32'(epc), 32'h37AB_6FB8);
    rd("mtc0_epc_rd", 5'd14, 32'hDEAD_BEE0);

    // Read map.
    rd("prid", 5'd15, 32'h0000_0001);
    rd("unmapped", 5'd3, 32'h0);
    mtc0(5'd15, 32'hFFFF_FFFF);
    rd("prid_ro", 5'd15, 32'h0000_0001);
    mtc0(5'd12, 32'hFFFF_FFFF);
    rd("sr_all6", 5'd12, 32'h0000_FC03);
    check("sr_all2", dout2, 32'h0000_0C03);

    // Asynchronous reset mid-handler.
    mtc0(5'd12, 32'h0);
    pulse_set(30'h0000_0100, 1'b0, 5'd0);
    check("pre_rst_epc", 32'(epc), 32'h0000_0100);
    check("pre_rst_exl", 32'(exl), 32'h1);
    sel = 5'd12;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_exl", 32'(exl), 32'h0);
    check("arst_epc", 32'(epc), 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    check("arst_sr", dout, 32'h0);
    tick();
    rst = 1'b1;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cp0_irq_ctrl.md
Name: cp0_irq_ctrl

Overview:
- Parametrised successor to the existing CP0: coprocessor-0 register file plus interrupt controller for the single-cycle MIPS core.
- Adds:
  - configurable interrupt line count
  - per-line level/edge mode, with edge lines latched until software acknowledges them
  - input synchronisers
  - synchronous exception codes in Cause
  - nested-exception EPC protection
- Sits between the controller (exl_set/exl_clr/we) and the IFU (irq, epc); dout feeds the register write-back mux.

Parameters:
- NUM_IRQ, 6: number of hardware interrupt lines; legal range 1..6.
- EDGE_MASK, 6'b000000: bit i = 1 makes line i edge-triggered; 0 makes it level-sensitive.
- SYNC_STAGES, 2: synchroniser depth on hwint; legal values 0 (bypass) or 2.
- PRID_VAL, 32'h0000_0001: value read from PRId.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc  in  30  word address [31:2] of the current instruction.
- din  in  32  mtc0 write data (busb).
- hwint  in  NUM_IRQ  hardware interrupt lines.
- sel  in  5  CP0 register number (rd field).
- we  in  1  mtc0 write enable.
- exl_set  in  1  controller is entering the handler this cycle.
- exl_clr  in  1  eret this cycle.
- exc_req  in  1  synchronous exception qualifier for exl_set.
- exc_code  in  5  ExcCode to record when exc_req = 1.
- irq  out  NUM_IRQ?no: 1  interrupt request to the controller/IFU.
- epc  out  30  EPC[31:2].
- exl  out  1  SR.EXL.
- dout  out  32  mfc0 read data.

Behaviour:
- Register map:
  - SR = 12: IM at bits [10 +: NUM_IRQ], EXL = bit 1, IE = bit 0; all other bits read 0.
  - Cause = 13: IP at [10 +: NUM_IRQ], ExcCode at [6:2]; all other bits read 0.
  - EPC = 14: reads {epc, 2'b00}.
  - PRId = 15: reads PRID_VAL.
  - Any other sel reads 32'h0.
- dout is combinational from sel and current register state.
- Reset (rst = 0, asynchronous): SR, ExcCode, edge pending bits, EPC and all synchroniser flops clear to 0. Resulting outputs: irq = 0, exl = 0, epc = 0. Reset asserted mid-handler drops EXL immediately.
- Synchroniser:
  - SYNC_STAGES = 2: hwint passes through two flops to give s[i]; a level change on hwint shows in s after 2 clock edges.
  - SYNC_STAGES = 0: s = hwint.
- Level lines: IP[i] = s[i] continuously. Not writable. The source must hold the line until serviced.
- Edge lines:
  - A previous-value flop p[i] tracks s[i].
  - Pending bit pend[i] sets on the edge where s[i] = 1 and p[i] = 0; IP[i] = pend[i].
  - pend[i] clears only on mtc0 to Cause with din[10+i] = 0.
  - If a new rising edge coincides with that clearing write, set wins.
  - Writing 1 to a pend bit has no effect.
- irq = IE & ~EXL & |(IP & IM). Combinational from registered state, so it is never asserted in reset.
- Latency (SYNC_STAGES = 2, IE = 1, IM = 1):
  - level line: irq rises 2 edges after hwint rises;
  - edge line: irq rises 3 edges after hwint rises.
- exl_set (sampled at the clock edge):
  - If EXL = 0: EPC <= pc.
  - If EXL = 1: EPC is unchanged (nested exception).
  - EXL <= 1 in both cases.
  - ExcCode <= exc_req ? exc_code : 5'd0 (0 = Int).
- exl_clr: EXL <= 0. EPC and ExcCode are unchanged.
- mtc0 writes (we = 1):
  - SR: IM, EXL and IE written from din.
  - Cause: only the edge-line pend bits are affected, clear-only as above.
  - EPC: EPC <= din[31:2].
  - PRId or unmapped sel: ignored.
- Simultaneous events, priority per field:
  - EXL: exl_set > exl_clr > mtc0 to SR.
  - EPC: exl_set (when EXL = 0) > mtc0 to EPC.
  - IM and IE are still written by mtc0 when it coincides with exl_set.
- exl_set with no pending cause and exc_req = 0 is legal: it records ExcCode 0.

Test Plan:
- Reset: assert rst = 0 mid-run with EXL = 1 and EPC = 30'h100 → exl = 0, epc = 0, irq = 0, dout (sel = 12) = 0, all immediately without waiting for a clock.
- Level interrupt:
  - Stimulus: SR = 32'h0000_0401 (IM0 = 1, IE = 1), hwint[0] raised at edge 0.
  - Response: irq = 1 after edge 2; Cause reads 32'h0000_0400.
  - Then exl_set with pc = 30'h0C00_0010 → epc = 30'h0C00_0010, exl = 1, irq = 0, ExcCode = 0.
- Edge interrupt (EDGE_MASK = 6'b000100):
  - Stimulus: 1-cycle pulse on hwint[2] with IM2 = 1 and IE = 1.
  - Response: irq = 1 from edge 3 onward and holds after the pulse ends.
  - Then mtc0 Cause din = 0 → irq = 0 next cycle.
  - Same test with a new rising edge colliding with the clear → pend[2] stays 1.
- Nested exception:
  - Stimulus: exl_set with exc_req = 1, exc_code = 5'd12, pc = A; then a second exl_set with pc = B while exl = 1.
  - Response: epc = A; ExcCode = 12 after the first set, updated by the second.
  - Then exl_clr → exl = 0; epc still A.
- Same-cycle collisions:
  - exl_set + exl_clr + mtc0 SR din = 0 → exl = 1, IE = 0.
  - exl_set (EXL = 0) + mtc0 EPC din = 32'hDEAD_BEE0 → epc = pc, not DEAD_BEE.
- Read map:
  - sel = 15 → PRID_VAL; sel = 3 → 0.
  - mtc0 to PRId → value unchanged.
  - NUM_IRQ = 2: SR bits above 11 read 0 after writing 32'hFFFF_FFFF.
